mdu_iter: RTL

//  Multi-cycle, parametrised multiply/divide unit for the RV32IM execute stage; full RV M-extension op set.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_operand_prep.sv | 55 +++++
 rtl/mdu_iter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constant helpers for the iterative multiply/divide unit (mdu_iter).
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  localparam int unsigned MAX_XLEN = 128;

  // Constants are built at MAX_XLEN width; callers keep the low xlen bits.
  function automatic logic [MAX_XLEN-1:0] min_neg_const(input int unsigned xlen);
    return MAX_XLEN'(1) << (xlen - 1);
  endfunction

  function automatic logic [MAX_XLEN-1:0] all_ones_const(input int unsigned xlen);
    return (MAX_XLEN'(1) << xlen) - MAX_XLEN'(1);
  endfunction

endpackage

// File: rtl/mdu_operand_prep.sv
// Combinational operand conditioning: magnitudes, sign flags, and the
// divide-by-zero / signed-overflow results that bypass the iterative core.
module mdu_operand_prep
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  op_e             op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic            prod_neg,
  output logic            rem_neg,
  output logic            is_div,
  output logic            special,
  output logic [XLEN-1:0] special_res
);

  localparam logic [MAX_XLEN-1:0] MIN_NEG_W = min_neg_const(XLEN);
  localparam logic [MAX_XLEN-1:0] ONES_W    = all_ones_const(XLEN);
  localparam logic [XLEN-1:0]     MIN_NEG   = MIN_NEG_W[XLEN-1:0];
  localparam logic [XLEN-1:0]     ONES      = ONES_W[XLEN-1:0];

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;
  logic is_quot;
  logic div_zero;
  logic div_ovf;

  always_comb begin
    a_signed = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op inside {OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_signed & rs1[XLEN-1];
    b_neg    = b_signed & rs2[XLEN-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
    is_div   = op[2];
    is_quot  = op inside {OP_DIV, OP_DIVU};
    // Quotient/product sign is the XOR of operand signs; remainder follows the dividend.
    prod_neg = a_neg ^ b_neg;
    rem_neg  = a_neg;
    div_zero = is_div && (rs2 == '0);
    div_ovf  = (op inside {OP_DIV, OP_REM}) && (rs1 == MIN_NEG) && (rs2 == ONES);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_res = is_quot ? ONES : rs1;
    end else begin
      special_res = is_quot ? rs1 : '0;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one op in flight.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_e            state;
  state_e            state_next;
  op_e               op_in;
  op_e               op_q;
  logic              neg_q;
  logic              rneg_q;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_next;
  logic [XLEN-1:0]   opnd;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              iterating;
  logic              last_iter;
  logic              fast_mul;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   special_res;
  logic              prod_neg;
  logic              rem_neg;
  logic              is_div;
  logic              special;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;

  assign op_in = op_e'(in_op);

  mdu_operand_prep #(.XLEN(XLEN)) u_prep (
    .op          (op_in),
    .rs1         (in_rs1),
    .rs2         (in_rs2),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .prod_neg    (prod_neg),
    .rem_neg     (rem_neg),
    .is_div      (is_div),
    .special     (special),
    .special_res (special_res)
  );

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fast_mul  = 1'b1;
`else
  assign fast_mul  = 1'b0;
`endif

  // Multiplies use the whole 2*XLEN word; divides hold remainder high, quotient low.
  function automatic logic [XLEN-1:0] finalize(input op_e op, input logic neg, input logic rneg,
                                               input logic [2*XLEN-1:0] v);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   r;
    p = neg  ? -v : v;
    q = neg  ? -v[XLEN-1:0] : v[XLEN-1:0];
    r = rneg ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                       return p[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return p[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              return q;
      default:                      return r;
    endcase
  endfunction

  assign accept    = in_valid && (state == S_IDLE) && !flush;
  assign iterating = (state == S_MUL) || (state == S_DIV);
  assign last_iter = (cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = rst_n && (state == S_IDLE) && !flush;
    out_valid  = (state == S_DONE);
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (special || (fast_mul && !is_div)) begin
            state_next = S_DONE;
          end else if (is_div) begin
            state_next = S_DIV;
          end else begin
            state_next = S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A same-cycle handshake also lands in IDLE, so flush simply overrides.
    if (flush) begin
      state_next = S_IDLE;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, opnd};
    div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    prod_next = prod;
    if (state == S_MUL) begin
      prod_next = prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
    end else if (state == S_DIV) begin
      // Negative trial difference means restore the shifted remainder.
      prod_next = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      opnd       <= '0;
      cnt        <= '0;
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      neg_q   <= prod_neg;
      rneg_q  <= rem_neg;
      cnt     <= '0;
      out_tag <= in_tag;
      opnd    <= is_div ? b_mag : a_mag;
      prod    <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      if (special) begin
        out_result <= special_res;
      end
`ifdef MDU_FAST_MUL_EN
      else if (!is_div) begin
        out_result <= finalize(op_in, prod_neg, rem_neg, fast_prod);
      end
`endif
    end else if (iterating) begin
      prod <= prod_next;
      if (last_iter) begin
        out_result <= finalize(op_q, neg_q, rneg_q, prod_next);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
